// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues sequential fetches (one outstanding),
// buffers returned words with their PCs, and presents them show-ahead to decode.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_valid,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_instr,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_pc_plus4,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_OCC = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

    state_t         state;
    logic [AW:0]    count;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_pc;
    logic [31:0]    mem_instr [DEPTH];
    logic [31:0]    mem_pc    [DEPTH];

    logic [AW+1:0]  occupancy;
    logic           issue;
    logic           push;
    logic           pop;

    // An outstanding request reserves a slot so its response always fits.
    assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, (state != IDLE)};

    assign issue = !Reset && !redirect && (occupancy < DEPTH_OCC) &&
                   ((state == IDLE) || ((state == WAIT) && imem_valid));
    assign push  = (state == WAIT) && imem_valid && !redirect;
    assign pop   = id_valid && id_ready;

    assign imem_req    = issue;
    assign imem_addr   = issue ? fetch_pc : 32'h0;
    assign id_valid    = (count != '0);
    assign id_instr    = id_valid ? mem_instr[rd_ptr] : 32'h0;
    assign id_pc       = id_valid ? mem_pc[rd_ptr] : 32'h0;
    assign id_pc_plus4 = id_valid ? mem_pc[rd_ptr] + 32'd4 : 32'h0;
    assign q_count     = count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= redirect_pc;
            case (state)
                WAIT:         state <= imem_valid ? IDLE : WAIT_DISCARD;
                WAIT_DISCARD: state <= imem_valid ? IDLE : WAIT_DISCARD;
                default:      state <= IDLE;
            endcase
        end else begin
            if (issue)
                fetch_pc <= fetch_pc + 32'd4;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case (state)
                IDLE:         state <= issue ? WAIT : IDLE;
                WAIT:         if (imem_valid) state <= issue ? WAIT : IDLE;
                WAIT_DISCARD: if (imem_valid) state <= IDLE;
                default:      state <= IDLE;
            endcase
        end
    end

    // Queue storage and request address are pure data; no reset needed.
    always_ff @(posedge Clk) begin
        if (issue)
            req_pc <= fetch_pc;
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= req_pc;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: latency-configurable memory model, directed
// scenarios, and a scoreboard monitor checking every accepted instruction.
module tb_if_prefetch_queue;

    logic        Clk;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [2:0]  q_count;

    int n_vec = 0;
    int n_err = 0;
    int lat   = 1;
    int n_req = 0;
    logic [31:0] exp_q[$];

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .Clk(Clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .q_count(q_count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Memory: one response per request, lat cycles after the request cycle.
    initial begin
        bit pend = 0;
        int cnt = 0;
        logic [31:0] paddr = 32'h0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge Clk);
            imem_valid = 1'b0;
            imem_rdata = 32'h0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = instr_of(paddr);
                    pend = 0;
                end
            end
            #1;
            if (imem_req === 1'b1) begin
                pend  = 1;
                cnt   = lat;
                paddr = imem_addr;
                n_req++;
            end
        end
    end

    // Scoreboard monitor: every accepted head entry must match the next expected PC.
    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge Clk);
            #2;
            if (id_valid === 1'b1 && id_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_entry: got pc %h, required no entry", id_pc);
                end else begin
                    pc = exp_q.pop_front();
                    chk("id_pc", id_pc, pc);
                    chk("id_instr", id_instr, instr_of(pc));
                    chk("id_pc_plus4", id_pc_plus4, pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset(input int l);
        Reset    = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        exp_q.delete();
        lat = l;
        cyc(4);
        n_req = 0;
        Reset = 1'b0;
    endtask

    task automatic check_drained(input string nm);
        #3;
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        Reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        lat         = 1;

        // Reset state
        cyc(1);
        #1;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("rst_q_count", {29'b0, q_count}, 32'd0);

        // Startup, latency 1
        cyc(2);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        id_ready = 1'b1;
        Reset    = 1'b0;
        #1;
        chk("start_req0", {31'b0, imem_req}, 32'd1);
        chk("start_addr0", imem_addr, 32'h0);
        cyc(1); #1;
        chk("start_addr1", imem_addr, 32'h4);
        chk("start_valid_c1", {31'b0, id_valid}, 32'd0);
        cyc(1); #1;
        chk("start_addr2", imem_addr, 32'h8);
        chk("start_valid_c2", {31'b0, id_valid}, 32'd1);
        chk("start_pc_c2", id_pc, 32'h0);
        cyc(8);
        id_ready = 1'b0;
        check_drained("start_drained");

        // Backpressure fill
        do_reset(1);
        cyc(5); #1;
        chk("bp_count4", {29'b0, q_count}, 32'd4);
        chk("bp_req_low", {31'b0, imem_req}, 32'd0);
        chk("bp_head_pc", id_pc, 32'h0);
        cyc(1); #2;
        chk("bp_num_req", 32'(n_req), 32'd4);
        cyc(1);
        exp_q.push_back(32'h0);
        id_ready = 1'b1;
        cyc(1);
        id_ready = 1'b0;
        #1;
        chk("bp_req_after_pop", {31'b0, imem_req}, 32'd1);
        chk("bp_addr_after_pop", imem_addr, 32'h10);
        chk("bp_count3", {29'b0, q_count}, 32'd3);
        cyc(1); #1;
        chk("bp_resp_valid", {31'b0, imem_valid}, 32'd1);
        chk("bp_req_gated", {31'b0, imem_req}, 32'd0);
        cyc(1);
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        exp_q.push_back(32'h10);
        id_ready = 1'b1;
        #1;
        chk("bp_count4_again", {29'b0, q_count}, 32'd4);
        cyc(4);
        id_ready = 1'b0;
        check_drained("bp_drained");

        // Redirect with response in flight, latency 3
        do_reset(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h100);
        id_ready = 1'b1;
        cyc(7);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("rdf_no_issue", {31'b0, imem_req}, 32'd0);
        cyc(1);
        redirect = 1'b0;
        #1;
        chk("rdf_count0", {29'b0, q_count}, 32'd0);
        chk("rdf_valid0", {31'b0, id_valid}, 32'd0);
        chk("rdf_req_wait", {31'b0, imem_req}, 32'd0);
        cyc(1); #1;
        chk("rdf_stale_resp", {31'b0, imem_valid}, 32'd1);
        chk("rdf_req_drop", {31'b0, imem_req}, 32'd0);
        cyc(1); #1;
        chk("rdf_req_target", {31'b0, imem_req}, 32'd1);
        chk("rdf_addr_target", imem_addr, 32'h100);
        cyc(5);
        id_ready = 1'b0;
        check_drained("rdf_drained");

        // Redirect coinciding with pop and response
        do_reset(1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h200);
        id_ready = 1'b1;
        cyc(3);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("rdc_resp", {31'b0, imem_valid}, 32'd1);
        chk("rdc_popping", {31'b0, id_valid}, 32'd1);
        chk("rdc_no_issue", {31'b0, imem_req}, 32'd0);
        cyc(1);
        redirect = 1'b0;
        #1;
        chk("rdc_count0", {29'b0, q_count}, 32'd0);
        chk("rdc_valid0", {31'b0, id_valid}, 32'd0);
        chk("rdc_req", {31'b0, imem_req}, 32'd1);
        chk("rdc_addr", imem_addr, 32'h200);
        cyc(3);
        id_ready = 1'b0;
        check_drained("rdc_drained");

        // Address wrap-around
        do_reset(1);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        chk("wrap_no_issue", {31'b0, imem_req}, 32'd0);
        cyc(1);
        redirect = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        cyc(1); #1;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        cyc(1); #1;
        chk("wrap_addr2", imem_addr, 32'h0);
        cyc(1); #1;
        chk("wrap_head_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", id_pc_plus4, 32'h0);
        cyc(2);
        id_ready = 1'b0;
        check_drained("wrap_drained");

        // Reset mid-operation, latency 3
        do_reset(3);
        cyc(10); #1;
        chk("mid_count3", {29'b0, q_count}, 32'd3);
        chk("mid_waiting", {31'b0, imem_req}, 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_imem_req", {31'b0, imem_req}, 32'd0);
        chk("mid_imem_addr", imem_addr, 32'h0);
        chk("mid_id_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_id_instr", id_instr, 32'h0);
        chk("mid_id_pc", id_pc, 32'h0);
        chk("mid_id_pc_plus4", id_pc_plus4, 32'h0);
        chk("mid_q_count", {29'b0, q_count}, 32'd0);
        cyc(2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        Reset    = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("mid_stray_resp", {31'b0, imem_valid}, 32'd1);
        chk("mid_restart_req", {31'b0, imem_req}, 32'd1);
        chk("mid_restart_addr", imem_addr, 32'h0);
        cyc(1); #1;
        chk("mid_stray_ignored", {29'b0, q_count}, 32'd0);
        cyc(7);
        id_ready = 1'b0;
        check_drained("mid_drained");

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
